// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types, constants and port-unpacking helper for the
//               multi-port register file with busy scoreboard.
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int BIT_DEPTH_DEF      = 32;
  localparam int LOG_PORT_DEPTH_DEF = 5;
  localparam int PACK_MAX           = 1024;
  localparam int SLICE_MAX          = 64;

  typedef logic [LOG_PORT_DEPTH_DEF-1:0] reg_addr_t;
  typedef logic [BIT_DEPTH_DEF-1:0]      reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  // Extracts slice idx (each width bits wide) from a zero-extended packed port bus.
  function automatic logic [SLICE_MAX-1:0] unpack_slice(
    input logic [PACK_MAX-1:0] vec,
    input int                  idx,
    input int                  width
  );
    return SLICE_MAX'(vec >> (idx * width)) &
           ((SLICE_MAX'(1) << width) - SLICE_MAX'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : per-register busy bits; flush > reserve > write-clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int LOG_PORT_DEPTH = LOG_PORT_DEPTH_DEF,
  parameter int NUM_WR         = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*LOG_PORT_DEPTH-1:0] wr_addr,
  input  logic                             rsv_en,
  input  logic [LOG_PORT_DEPTH-1:0]        rsv_addr,
  input  logic                             flush,
  output logic [(2**LOG_PORT_DEPTH)-1:0]   busy_vec
);

  localparam int c_nreg = 2**LOG_PORT_DEPTH;

  logic [c_nreg-1:0] r_busy;
  logic [c_nreg-1:0] w_wr_hit;
  logic [c_nreg-1:0] w_rsv_hit;

  always_comb begin
    w_wr_hit  = '0;
    w_rsv_hit = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p])
        w_wr_hit[LOG_PORT_DEPTH'(unpack_slice(PACK_MAX'(wr_addr), p, LOG_PORT_DEPTH))] = 1'b1;
    end
    if (rsv_en && (rsv_addr != LOG_PORT_DEPTH'(REG_ZERO)))
      w_rsv_hit[rsv_addr] = 1'b1;
  end

  // A same-cycle reserve overrides the clear: the newer producer owns the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_busy <= '0;
    else if (flush)
      r_busy <= '0;
    else
      r_busy <= (r_busy & ~w_wr_hit) | w_rsv_hit;
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// ============================================================================
// regfile_mp_sb : NUM_RD async read / NUM_WR sync write register file with
//                 busy scoreboard; optional forwarding via REGFILE_BYPASS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int BIT_DEPTH      = BIT_DEPTH_DEF,
  parameter int LOG_PORT_DEPTH = LOG_PORT_DEPTH_DEF,
  parameter int NUM_RD         = 2,
  parameter int NUM_WR         = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*LOG_PORT_DEPTH-1:0] rd_addr,
  output logic [NUM_RD*BIT_DEPTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*LOG_PORT_DEPTH-1:0] wr_addr,
  input  logic [NUM_WR*BIT_DEPTH-1:0]      wr_data,
  input  logic                             rsv_en,
  input  logic [LOG_PORT_DEPTH-1:0]        rsv_addr,
  input  logic                             flush,
  output logic [(2**LOG_PORT_DEPTH)-1:0]   busy_vec
);

  localparam int c_nreg = 2**LOG_PORT_DEPTH;

  logic [BIT_DEPTH-1:0]      r_regs    [c_nreg];
  logic [LOG_PORT_DEPTH-1:0] w_wr_addr [NUM_WR];
  logic [BIT_DEPTH-1:0]      w_wr_data [NUM_WR];
  logic [c_nreg-1:0]         w_busy_vec;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign w_wr_addr[p] = LOG_PORT_DEPTH'(unpack_slice(PACK_MAX'(wr_addr), p, LOG_PORT_DEPTH));
    assign w_wr_data[p] = wr_data[p*BIT_DEPTH +: BIT_DEPTH];
  end

  // Ascending port loop: the last non-blocking assignment wins, so the highest index has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < c_nreg; r++)
        r_regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (w_wr_addr[p] != LOG_PORT_DEPTH'(REG_ZERO)))
          r_regs[w_wr_addr[p]] <= w_wr_data[p];
      end
    end
  end

  regfile_scoreboard #(
    .LOG_PORT_DEPTH (LOG_PORT_DEPTH),
    .NUM_WR         (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [LOG_PORT_DEPTH-1:0] w_addr;
    logic [BIT_DEPTH-1:0]      w_data;
    logic                      w_busy;

    assign w_addr = LOG_PORT_DEPTH'(unpack_slice(PACK_MAX'(rd_addr), i, LOG_PORT_DEPTH));

    always_comb begin
      w_data = r_regs[w_addr];
      w_busy = w_busy_vec[w_addr];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (w_wr_addr[p] != LOG_PORT_DEPTH'(REG_ZERO)) && (w_wr_addr[p] == w_addr)) begin
          w_data = w_wr_data[p];
          if (!(rsv_en && (rsv_addr == w_addr)))
            w_busy = 1'b0;
        end
      end
`endif
      if (w_addr == LOG_PORT_DEPTH'(REG_ZERO)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign rd_data[i*BIT_DEPTH +: BIT_DEPTH] = w_data;
    assign rd_busy[i]                        = w_busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// ============================================================================
// tb_regfile_mp_sb : directed and randomised self-checking bench for
//                    regfile_mp_sb (NUM_RD=2, NUM_WR=2).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [31:0] busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  regfile_mp_sb #(
    .BIT_DEPTH      (32),
    .LOG_PORT_DEPTH (5),
    .NUM_RD         (2),
    .NUM_WR         (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = wr_addr[p*5 +: 5];
      if (wr_en[p] && a != 5'd0) m_regs[a] = wr_data[p*32 +: 32];
    end
    if (flush) begin
      m_busy = '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) m_busy[wr_addr[p*5 +: 5]] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
    end
    m_busy[0] = 1'b0;
  endtask

  task automatic check_model();
    logic [4:0]  a;
    logic [4:0]  wa;
    logic [31:0] e_d;
    logic        e_b;
    for (int i = 0; i < 2; i++) begin
      a   = rd_addr[i*5 +: 5];
      e_d = (a == 5'd0) ? 32'd0 : m_regs[a];
      e_b = (a == 5'd0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        wa = wr_addr[p*5 +: 5];
        if (wr_en[p] && wa != 5'd0 && wa == a) begin
          e_d = wr_data[p*32 +: 32];
          if (!(rsv_en && rsv_addr == a)) e_b = 1'b0;
        end
      end
`else
      wa = '0;
`endif
      chk($sformatf("rand_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(e_d));
      chk($sformatf("rand_busy%0d", i), 64'(rd_busy[i]), 64'(e_b));
    end
    chk("rand_busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", rd_data, 64'd0);
    chk("reset_busy_vec", 64'(busy_vec), 64'd0);
    rst_n = 1'b1;

    // Write reg5 and reserve reg9, then reset asynchronously mid-cycle.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("pre_rst_data", rd_data, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("pre_rst_busy_vec", 64'(busy_vec), 64'h200);
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", rd_data, 64'd0);
    chk("async_rst_busy_vec", 64'(busy_vec), 64'd0);
    chk("async_rst_rd_busy", 64'(rd_busy), 64'd0);
    #2 rst_n = 1'b1;

    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'hFFFFFFFF};
    tick(); idle();
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_reg", rd_data, 64'd0);

    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h12345678};
    rd_addr = {5'd3, 5'd3};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_cycle", 64'(rd_data[31:0]), 64'h12345678);
`else
    chk("rw_same_cycle", 64'(rd_data[31:0]), 64'd0);
`endif
    tick(); idle();
    #1;
    chk("rw_next_cycle", rd_data, {32'h12345678, 32'h12345678});

    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
    tick(); idle();
    rd_addr = {5'd7, 5'd3};
    #1;
    chk("wr_conflict", rd_data, {32'h5555FFFF, 32'h12345678});

    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = {5'd9, 5'd9};
    #1;
    chk("rsv_pre_edge", 64'(rd_busy), 64'd0);
    tick(); idle();
    #1;
    chk("rsv_busy", 64'(rd_busy), 64'h3);
    chk("rsv_busy_vec", 64'(busy_vec), 64'h200);
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h1, 32'h0};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wb_same_cycle_busy", 64'(rd_busy), 64'h0);
`else
    chk("wb_same_cycle_busy", 64'(rd_busy), 64'h3);
`endif
    tick(); idle();
    #1;
    chk("wb_clear_busy", 64'(rd_busy), 64'h0);
    chk("wb_data", rd_data, {32'h1, 32'h1});
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h2};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick(); idle();
    #1;
    chk("rsv_over_wb_busy", 64'(rd_busy), 64'h3);
    chk("rsv_over_wb_data", 64'(rd_data[31:0]), 64'h2);

    // Reserve 1, 2, 31 then flush with a concurrent reserve and write.
    rsv_en = 1'b1; rsv_addr = 5'd1;  tick();
    rsv_addr = 5'd2;  tick();
    rsv_addr = 5'd31; tick(); idle();
    #1;
    chk("pre_flush_busy_vec", 64'(busy_vec), 64'h80000206);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'h0, 32'hCAFE};
    tick(); idle();
    rd_addr = {5'd4, 5'd10};
    #1;
    chk("flush_busy_vec", 64'(busy_vec), 64'd0);
    chk("flush_wr_data", 64'(rd_data[31:0]), 64'hCAFE);

    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_busy = '0;
    for (int c = 0; c < 10000; c++) begin
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      wr_data  = {$urandom, $urandom};
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 31));
      flush    = ($urandom_range(0, 63) == 0);
      rd_addr  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      #1;
      check_model();
      model_step();
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
